// File: rtl/riscv_crypto_sm4_pkg.sv
// Shared types, constants and linear helpers for the iterative SM4 block engine.
// Words are big-endian: word 0 of a 128-bit value sits in bits [127:96].
package riscv_crypto_sm4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_READY,
    S_ROUND,
    S_DONE
  } sm4_state_e;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // CK_i byte j = ((4i + j) * 7) mod 256, byte 0 in the most significant position.
  function automatic logic [31:0] ck_gen(input logic [4:0] i);
    logic [31:0] ck;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[8*(3-j) +: 8] = 8'((4 * int'(i) + j) * 7);
    end
    return ck;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] lin_enc(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] lin_key(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [127:0] swap_words(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

endpackage

// File: rtl/riscv_crypto_sm4_sbox.sv
// Single-byte SM4 S-box as a constant lookup table.
module riscv_crypto_sm4_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0 occupies the top byte, so entry k starts at bit 8*(255-k).
  localparam logic [2047:0] TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign out_o = TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/riscv_crypto_sm4_tau.sv
// SM4 non-linear word transform tau: four parallel byte S-boxes, purely combinational.
module riscv_crypto_sm4_tau (
  input  logic [31:0] a_i,
  output logic [31:0] b_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    riscv_crypto_sm4_sbox u_sbox (
      .in_i (a_i[8*g +: 8]),
      .out_o(b_o[8*g +: 8])
    );
  end

endmodule

// File: rtl/riscv_crypto_sm4_core.sv
// Iterative SM4 engine: expands a master key into 32 stored round keys, then runs
// one round per cycle to encrypt or decrypt a 128-bit block.
module riscv_crypto_sm4_core
  import riscv_crypto_sm4_pkg::*;
#(
  parameter int NROUNDS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_in,
  input  logic         blk_mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_out,
  output logic         busy
);

  localparam logic [4:0] LAST = 5'(NROUNDS - 1);

  sm4_state_e   state_q, state_d;
  logic         keys_ok_q, keys_ok_d;
  logic         mode_q, mode_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] win_q, win_d;
  logic [31:0]  rk_q [32];
  logic         rk_we;
  logic [31:0]  rk_sel, tau_in, tau_out, new_word;
  logic         key_hs, blk_hs;

  assign key_ready = (state_q == S_IDLE) || (state_q == S_READY);
  assign blk_ready = (state_q == S_READY) && keys_ok_q && !key_valid;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_KEYEXP) || (state_q == S_ROUND) || (state_q == S_DONE);
  assign res_out   = swap_words(win_q);
  assign key_hs    = key_valid && key_ready;
  assign blk_hs    = blk_valid && blk_ready;

  // Key expansion and rounds share the one tau instance and the 4-word window.
  always_comb begin
    rk_sel = rk_q[mode_q ? 5'(LAST - cnt_q) : cnt_q];
    if (state_q == S_KEYEXP) begin
      tau_in   = win_q[95:64] ^ win_q[63:32] ^ win_q[31:0] ^ ck_gen(cnt_q);
      new_word = win_q[127:96] ^ lin_key(tau_out);
    end else begin
      tau_in   = win_q[95:64] ^ win_q[63:32] ^ win_q[31:0] ^ rk_sel;
      new_word = win_q[127:96] ^ lin_enc(tau_out);
    end
  end

  riscv_crypto_sm4_tau u_tau (
    .a_i(tau_in),
    .b_o(tau_out)
  );

  always_comb begin
    state_d   = state_q;
    keys_ok_d = keys_ok_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    rk_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_hs) begin
          win_d   = key_in ^ FK;
          cnt_d   = '0;
          state_d = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        rk_we = 1'b1;
        win_d = {win_q[95:0], new_word};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          keys_ok_d = 1'b1;
          state_d   = S_READY;
        end
      end
      S_READY: begin
        // A key offered together with a block takes priority.
        if (key_hs) begin
          win_d   = key_in ^ FK;
          cnt_d   = '0;
          state_d = S_KEYEXP;
        end else if (blk_hs) begin
          win_d   = blk_in;
          mode_d  = blk_mode;
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        win_d = {win_q[95:0], new_word};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      keys_ok_q <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      keys_ok_q <= keys_ok_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
    end
  end

  // The round-key file needs no reset; it is always rewritten before any block runs.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[cnt_q] <= new_word;
  end

endmodule

// File: tb/tb_riscv_crypto_sm4_core.sv
// Randomised scoreboard bench for the SM4 core against a straight-line SM4 reference model.
module tb_riscv_crypto_sm4_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         keyValid = 1'b0;
  logic [127:0] keyIn = '0;
  logic         blkValid = 1'b0;
  logic [127:0] blkIn = '0;
  logic         blkMode = 1'b0;
  logic         resReady = 1'b1;
  logic         keyReady, blkReady, resValid, busy;
  logic [127:0] resOut;

  riscv_crypto_sm4_core #(.NROUNDS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(keyValid),
    .key_ready(keyReady),
    .key_in   (keyIn),
    .blk_valid(blkValid),
    .blk_ready(blkReady),
    .blk_in   (blkIn),
    .blk_mode (blkMode),
    .res_valid(resValid),
    .res_ready(resReady),
    .res_out  (resOut),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [127:0] expQ[$];
  int acceptQ[$];
  int lastAccept = 0;
  int lastKeyEdge = 0;
  bit resSeen = 1'b0;
  logic [127:0] monExp;
  int monAcc;

  logic [2047:0] sboxBits = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  logic [31:0] fkTab [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  logic [31:0] modelRk [32];

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tauM(input logic [31:0] a);
    logic [31:0] r;
    int b;
    for (int j = 0; j < 4; j++) begin
      b = int'(a[8*j +: 8]);
      r[8*j +: 8] = sboxBits[8*(255-b) +: 8];
    end
    return r;
  endfunction

  function automatic void expandKey(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck, t;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fkTab[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      t = tauM(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rotl32(t, 13) ^ rotl32(t, 23);
      modelRk[i] = k[i+4];
    end
  endfunction

  function automatic logic [127:0] cryptModel(input logic [127:0] blk, input logic dec);
    logic [31:0] x [36];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      t = tauM(x[i+1] ^ x[i+2] ^ x[i+3] ^ modelRk[dec ? 31 - i : i]);
      x[i+4] = x[i] ^ t ^ rotl32(t, 2) ^ rotl32(t, 10) ^ rotl32(t, 18) ^ rotl32(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: pops one expected entry each time a new result appears.
  always @(negedge clk) begin
    if (resValid && !resSeen) begin
      resSeen = 1'b1;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%h required=none", resOut);
      end else begin
        monExp = expQ.pop_front();
        monAcc = acceptQ.pop_front();
        checkOutput("result", resOut, monExp);
        checkOutput("latency", 128'(cyc - monAcc), 128'd32);
      end
    end else if (!resValid) begin
      resSeen = 1'b0;
    end
  end

  task automatic loadKey(input logic [127:0] k, input bit measure);
    int n = 0;
    int low = 0;
    keyIn = k;
    keyValid = 1'b1;
    @(negedge clk);
    while (!keyReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!keyReady) timeoutFail("key_accept");
    lastKeyEdge = cyc + 1;
    @(posedge clk);
    #1 keyValid = 1'b0;
    expandKey(k);
    if (measure) begin
      @(negedge clk);
      checkOutput("busy_keyexp", 128'(busy), 128'd1);
      while (!keyReady && low < 100) begin
        low++;
        @(negedge clk);
      end
      checkOutput("key_ready_low_cycles", 128'(low), 128'd32);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [127:0] data, input logic mode, input logic [127:0] expected);
    int n = 0;
    blkIn = data;
    blkMode = mode;
    blkValid = 1'b1;
    @(negedge clk);
    while (!blkReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!blkReady) begin
      timeoutFail("blk_accept");
    end else begin
      lastAccept = cyc + 1;
      expQ.push_back(expected);
      acceptQ.push_back(lastAccept);
    end
    @(posedge clk);
    #1 blkValid = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!resValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!resValid) timeoutFail(name);
  endtask

  task automatic drainResult(input int hold);
    int n = 0;
    waitValid("res_valid");
    repeat (hold) @(negedge clk);
    resReady = 1'b1;
    while (resValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (resValid) timeoutFail("res_release");
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_key_ready"}, 128'(keyReady), 128'd1);
    checkOutput({tag, "_blk_ready"}, 128'(blkReady), 128'd0);
    checkOutput({tag, "_res_valid"}, 128'(resValid), 128'd0);
    checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
    checkOutput({tag, "_res_out"}, resOut, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] kat, p, e;
    int releaseEdge, hold;
    logic m;
    kat = 128'h0123456789ABCDEFFEDCBA9876543210;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;

    $display("[TB] known-answer key, encrypt and decrypt");
    loadKey(kat, 1'b1);
    applyStimulus(kat, 1'b0, 128'h681EDF34D206965E86B3E94F536E4246);
    drainResult(0);
    applyStimulus(128'h681EDF34D206965E86B3E94F536E4246, 1'b1, kat);
    drainResult(0);

    $display("[TB] result back-pressure and minimum initiation interval");
    p = rand128();
    e = cryptModel(p, 1'b0);
    resReady = 1'b0;
    applyStimulus(p, 1'b0, e);
    waitValid("hold_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_res_out", resOut, e);
      checkOutput("hold_res_valid", 128'(resValid), 128'd1);
      checkOutput("hold_blk_ready", 128'(blkReady), 128'd0);
    end
    resReady = 1'b1;
    releaseEdge = cyc + 1;
    @(posedge clk);
    #1;
    p = rand128();
    applyStimulus(p, 1'b1, cryptModel(p, 1'b1));
    checkOutput("next_accept_edge", 128'(lastAccept), 128'(releaseEdge + 1));
    drainResult(0);

    $display("[TB] key and block offered together");
    keyIn = rand128();
    keyValid = 1'b1;
    p = rand128();
    blkIn = p;
    blkMode = 1'b0;
    blkValid = 1'b1;
    @(negedge clk);
    checkOutput("collide_blk_ready", 128'(blkReady), 128'd0);
    checkOutput("collide_key_ready", 128'(keyReady), 128'd1);
    lastKeyEdge = cyc + 1;
    @(posedge clk);
    #1 keyValid = 1'b0;
    expandKey(keyIn);
    applyStimulus(p, 1'b0, cryptModel(p, 1'b0));
    checkOutput("collide_accept_edge", 128'(lastAccept), 128'(lastKeyEdge + 33));
    drainResult(0);

    $display("[TB] randomised blocks with occasional re-key");
    for (int n = 0; n < 10; n++) begin
      if (n % 4 == 3) loadKey(rand128(), 1'b1);
      p = rand128();
      m = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 4);
      resReady = (hold == 0);
      applyStimulus(p, m, cryptModel(p, m));
      drainResult(hold);
    end

    $display("[TB] reset in the middle of a block");
    p = rand128();
    applyStimulus(p, 1'b0, cryptModel(p, 1'b0));
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    expQ.delete();
    acceptQ.delete();
    @(negedge clk);
    checkResetValues("midreset");
    blkIn = rand128();
    blkValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_reset_blk_ready", 128'(blkReady), 128'd0);
    end
    @(posedge clk);
    #1 blkValid = 1'b0;
    loadKey(rand128(), 1'b1);
    p = rand128();
    applyStimulus(p, 1'b1, cryptModel(p, 1'b1));
    drainResult(0);

    checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
